vrf_read_sequencer: RTL



---
 rtl/vrf_read_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/vrf_read_sequencer.sv
// -----------------------------------------------------------------------------
// vrf_read_sequencer
//
// Issues the ordered stream of VRF read requests for one vector-instruction
// operand, walking every (group, offset) pair, and limits the number of reads
// in flight with a credit counter sized to the read-pipe data FIFO. A one-cycle
// done pulse is raised once every issued read's data has been consumed.
//
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   cmd_valid / cmd_ready        operand read command handshake (ready = idle)
//   cmd_bits_*                   base register, tags and last group/offset
//   kill                         abort the current command
//   enqueue_valid / _ready       request handshake towards the read pipe
//   enqueue_bits_*               registered request fields
//   data_fire                    one read-pipe dequeue, returns one credit
//   done / done_killed           completion pulse and its abort qualifier
// -----------------------------------------------------------------------------
module vrf_read_sequencer #(
  parameter int CREDITS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [4:0] cmd_bits_vs,
  input  logic [3:0] cmd_bits_readSource,
  input  logic [2:0] cmd_bits_instructionIndex,
  input  logic [3:0] cmd_bits_lastGroup,
  input  logic [3:0] cmd_bits_lastOffset,
  input  logic       kill,
  input  logic       enqueue_ready,
  output logic       enqueue_valid,
  output logic [4:0] enqueue_bits_vs,
  output logic [3:0] enqueue_bits_offset,
  output logic [3:0] enqueue_bits_groupIndex,
  output logic [3:0] enqueue_bits_readSource,
  output logic [2:0] enqueue_bits_instructionIndex,
  input  logic       data_fire,
  output logic       done,
  output logic       done_killed
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] CREDIT_FULL = 3'(CREDITS);

  state_e     state_q, state_d;
  logic [2:0] credit_q, credit_d;
  logic [3:0] group_q, group_d;
  logic [3:0] offset_q, offset_d;
  logic [4:0] vs_q, vs_d;
  logic [3:0] rs_q, rs_d;
  logic [2:0] ii_q, ii_d;
  logic [3:0] last_group_q, last_group_d;
  logic [3:0] last_offset_q, last_offset_d;
  logic       killed_q, killed_d;

  logic       enq_valid_s;
  logic       fire_s;
  logic       last_req_s;

  // A request is offered only with a credit in hand; kill suppresses it at once.
  assign enq_valid_s = (state_q == S_ISSUE) && (credit_q != 3'd0) && !kill;
  assign fire_s      = enq_valid_s && enqueue_ready;
  assign last_req_s  = (group_q == last_group_q) && (offset_q == last_offset_q);

  // Credit update: fire consumes, data_fire returns, both together cancel.
  always_comb begin
    credit_d = credit_q;
    case ({fire_s, data_fire})
      2'b10: credit_d = credit_q - 3'd1;
      2'b01: begin
        // A return while already full is a protocol error; hold at full.
        if (credit_q == CREDIT_FULL) begin
          credit_d = CREDIT_FULL;
        end else begin
          credit_d = credit_q + 3'd1;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  // Next-state, iteration counters and handshake outputs.
  always_comb begin
    state_d       = state_q;
    group_d       = group_q;
    offset_d      = offset_q;
    vs_d          = vs_q;
    rs_d          = rs_q;
    ii_d          = ii_q;
    last_group_d  = last_group_q;
    last_offset_d = last_offset_q;
    killed_d      = killed_q;
    cmd_ready     = 1'b0;
    done          = 1'b0;
    done_killed   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        killed_d  = 1'b0;
        if (cmd_valid) begin
          vs_d          = cmd_bits_vs;
          rs_d          = cmd_bits_readSource;
          ii_d          = cmd_bits_instructionIndex;
          last_group_d  = cmd_bits_lastGroup;
          last_offset_d = cmd_bits_lastOffset;
          group_d       = 4'd0;
          offset_d      = 4'd0;
          state_d       = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        if (kill) begin
          killed_d = 1'b1;
          state_d  = S_DRAIN;
        end else if (fire_s) begin
          if (last_req_s) begin
            state_d = S_DRAIN;
          end else if (offset_q == last_offset_q) begin
            offset_d = 4'd0;
            group_d  = group_q + 4'd1;
          end else begin
            offset_d = offset_q + 4'd1;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_DRAIN: begin
        if (kill) begin
          killed_d = 1'b1;
        end else begin
          killed_d = killed_q;
        end
        // Look at the next credit value so the final return finishes at once.
        if (credit_d == CREDIT_FULL) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_DONE: begin
        done        = 1'b1;
        done_killed = killed_q;
        killed_d    = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      credit_q      <= CREDIT_FULL;
      group_q       <= 4'd0;
      offset_q      <= 4'd0;
      vs_q          <= 5'd0;
      rs_q          <= 4'd0;
      ii_q          <= 3'd0;
      last_group_q  <= 4'd0;
      last_offset_q <= 4'd0;
      killed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      group_q       <= group_d;
      offset_q      <= offset_d;
      vs_q          <= vs_d;
      rs_q          <= rs_d;
      ii_q          <= ii_d;
      last_group_q  <= last_group_d;
      last_offset_q <= last_offset_d;
      killed_q      <= killed_d;
    end
  end

  assign enqueue_valid                 = enq_valid_s;
  assign enqueue_bits_vs               = vs_q;
  assign enqueue_bits_offset           = offset_q;
  assign enqueue_bits_groupIndex       = group_q;
  assign enqueue_bits_readSource       = rs_q;
  assign enqueue_bits_instructionIndex = ii_q;

endmodule
